dec_trig_commit: RTL

DEC_TRIG_COMMIT -- requirements
Module: dec_trig_commit

---
 rtl/swerv_types.sv | 17 +
 rtl/dec_trig_chain.sv | 18 +
 rtl/rvdffe.sv | 20 ++
 rtl/dec_trig_commit.sv | 109 ++++++++++
 4 files changed

// File: rtl/swerv_types.sv
// Shared types for the decode-to-commit trigger pipeline; no logic, no latency.
package swerv_types;

    typedef struct packed {
        logic       i0_valid;
        logic [3:0] i0_match;
        logic       i1_valid;
        logic [3:0] i1_match;
    } trig_pipe_pkt_t;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        HALT_PEND = 2'd1,
        HALT_ACT  = 2'd2
    } trig_state_e;

endpackage

// File: rtl/dec_trig_chain.sv
// Pair chaining of trigger matches; purely combinational, no backpressure.
module dec_trig_chain (
    input  logic [3:0] match_in,
    input  logic [1:0] chain,
    output logic [3:0] match_out
);

    // A chained pair only survives when both of its triggers hit the same instruction.
    always_comb begin
        match_out = match_in;
        for (int k = 0; k < 2; k++) begin
            if (chain[k] && (match_in[2*k +: 2] != 2'b11)) begin
                match_out[2*k +: 2] = 2'b00;
            end
        end
    end

endmodule

// File: rtl/rvdffe.sv
// Enabled flop cell with async active-low clear; one clock latency, holds when en is low.
module rvdffe #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_l,
    input  logic             en,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            dout <= '0;
        end else if (en) begin
            dout <= din;
        end
    end

endmodule

// File: rtl/dec_trig_commit.sv
// Carries trigger matches decode->E4 and commits hit/ebreak/halt; TRIG_DEPTH clocks latency.
// Freeze holds every stage and blocks firing; flush clears all stages at the next edge.
module dec_trig_commit
    import swerv_types::*;
#(
    parameter int TRIG_DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst_l,
    input  logic [3:0] dec_i0_trigger_match_d,
    input  logic [3:0] dec_i1_trigger_match_d,
    input  logic       dec_i0_decode_d,
    input  logic       dec_i1_decode_d,
    input  logic       dec_pipe_freeze,
    input  logic       dec_tlu_flush_lower_wb,
    input  logic [1:0] trig_chain,
    input  logic [3:0] trig_action,
    input  logic       dec_tlu_debug_mode,
    input  logic       dbg_halt_ack,
    output logic [3:0] trig_hit_e4,
    output logic       trig_ebreak_e4,
    output logic       trig_i1_fire_e4,
    output logic       dbg_halt_req
);

    logic [3:0]     i0_chained;
    logic [3:0]     i1_chained;
    trig_pipe_pkt_t capture;
    trig_pipe_pkt_t stage_d [TRIG_DEPTH];
    trig_pipe_pkt_t stage_q [TRIG_DEPTH];
    trig_pipe_pkt_t e4;
    logic           stage_en;
    logic           fire_ok;
    logic           i0_fire;
    logic           i1_fire;
    logic           halt_fire;
    trig_state_e    state_q;
    trig_state_e    state_d;

    dec_trig_chain u_chain_i0 (
        .match_in  (dec_i0_trigger_match_d),
        .chain     (trig_chain),
        .match_out (i0_chained)
    );

    dec_trig_chain u_chain_i1 (
        .match_in  (dec_i1_trigger_match_d),
        .chain     (trig_chain),
        .match_out (i1_chained)
    );

    always_comb begin
        capture          = '0;
        capture.i0_valid = dec_i0_decode_d;
        capture.i0_match = dec_i0_decode_d ? i0_chained : 4'b0;
        capture.i1_valid = dec_i1_decode_d;
        capture.i1_match = dec_i1_decode_d ? i1_chained : 4'b0;
    end

    // Flush must win over freeze, so it also opens the stage enables.
    assign stage_en = ~dec_pipe_freeze | dec_tlu_flush_lower_wb;

    for (genvar s = 0; s < TRIG_DEPTH; s++) begin : g_stage
        if (s == 0) begin : g_first
            assign stage_d[s] = dec_tlu_flush_lower_wb ? trig_pipe_pkt_t'('0) : capture;
        end else begin : g_next
            assign stage_d[s] = dec_tlu_flush_lower_wb ? trig_pipe_pkt_t'('0) : stage_q[s-1];
        end

        rvdffe #(.WIDTH($bits(trig_pipe_pkt_t))) u_stage_ff (
            .clk   (clk),
            .rst_l (rst_l),
            .en    (stage_en),
            .din   (stage_d[s]),
            .dout  (stage_q[s])
        );
    end

    assign e4 = stage_q[TRIG_DEPTH-1];

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Outputs stay unqualified by flush: an entry already in E4 still commits.
    always_comb begin
        state_d         = state_q;
        fire_ok         = ~dec_pipe_freeze & ~dec_tlu_debug_mode & (state_q == IDLE);
        i0_fire         = fire_ok & e4.i0_valid & (|e4.i0_match);
        i1_fire         = fire_ok & ~i0_fire & e4.i1_valid & (|e4.i1_match);
        trig_hit_e4     = i0_fire ? e4.i0_match : (i1_fire ? e4.i1_match : 4'b0);
        halt_fire       = |(trig_hit_e4 & trig_action);
        trig_ebreak_e4  = (i0_fire | i1_fire) & ~halt_fire;
        trig_i1_fire_e4 = i1_fire;
        dbg_halt_req    = (state_q == HALT_PEND);

        case (state_q)
            IDLE:      if (halt_fire)           state_d = HALT_PEND;
            HALT_PEND: if (dbg_halt_ack)        state_d = HALT_ACT;
            HALT_ACT:  if (!dec_tlu_debug_mode) state_d = IDLE;
            default:                            state_d = IDLE;
        endcase
    end

endmodule
